pipeline_trace_tracker: RTL and testbench
=========================================

Name: pipeline_trace_tracker

Overview:
- Cycle-stamped instruction tracer for an in-order RISC-V core with an OBI-style instruction bus.
- Follows each fetched instruction through three stages:
  - IF: request granted until rvalid.
  - ID: rvalid until decode ends.
  - EX: memory request until response, for loads/stores.
- Emits one complete trace_format record per retired instruction, in program order.
- Sits between core probe signals and the trace sink; the free-running cycle counter comes from the parent.

Parameters:
- INSTR_ADDR_WIDTH, 16: instruction address bits; zero-extended into the 32-bit record field.
- INSTR_DATA_WIDTH, 32: instruction word width.
- DATA_ADDR_WIDTH, 32: data address width.
- IF_TRACKER_BUFFER_SIZE, 8: depth of the IF pending FIFO and the IF fetched FIFO (each).
- TRACE_BUFFER_SIZE, 8: depth of the EX in-order queue.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- counter  in  32 signed  cycle counter, sampled for all timestamps.
- instr_req  in  1  fetch request.
- instr_gnt  in  1  fetch grant.
- instr_addr  in  INSTR_ADDR_WIDTH  fetch address.
- instr_rvalid  in  1  fetch response valid.
- instr_rdata  in  INSTR_DATA_WIDTH  fetched word.
- decode_phase_end  in  1  ID stage hands its instruction to EX this cycle.
- pc_set  in  1  PC redirect; all prefetched, undecoded instructions are invalid.
- data_mem_req  in  1  data request.
- data_mem_addr  in  DATA_ADDR_WIDTH  data address.
- data_mem_rvalid  in  1  data response valid.
- trace_data_o  out  trace_format  completed record.
- trace_valid  out  1  one-cycle pulse; trace_data_o is valid.
- repeat_detected  out  1  sticky end-of-program flag.
- overflow  out  1  sticky; some record was dropped.

Behaviour:
- Reset:
  - Clock clk; reset rst_n, synchronous, active-low.
  - All FIFOs empty, discard counter 0.
  - trace_valid, repeat_detected and overflow all 0; trace_data_o all zero.
- IF pending FIFO:
  - On a sampled edge with instr_req && instr_gnt, push {addr, if_start = counter}.
- On instr_rvalid, when the pending FIFO is non-empty:
  - Pop the pending head.
  - Fill instruction = instr_rdata and if_end = counter.
  - Push the result into the fetched FIFO.
  - rvalid with an empty pending FIFO is ignored.
  - A grant and an rvalid in the same cycle are both processed; the pop applies to the prior head.
- On decode_phase_end, when the fetched FIFO is non-empty:
  - Pop the fetched head.
  - Set id_start = if_end and id_end = counter.
  - Push into the EX queue.
- On pc_set:
  - Clear the fetched FIFO.
  - Set the discard counter to the current pending occupancy; that many following rvalids are popped and dropped.
  - A decode_phase_end in the same cycle is honoured before the flush.
  - An rvalid in the same cycle is discarded.
  - A grant in the same cycle is kept: it is the redirect target.
- EX classification on entry, by opcode bits [6:0]:
  - 0000011 (load) or 0100011 (store) is a memory op.
  - Any other opcode: ex_start = id_end, ex_end = id_end + 1, mem_addr = 0, done immediately.
- Memory ops, resolved in queue order:
  - The oldest un-requested memory op takes the data_mem_req edge: ex_start = counter, mem_addr = data_mem_addr.
  - The oldest requested, not-done op takes the data_mem_rvalid edge: ex_end = counter, done.
  - req and rvalid may hit different entries in the same cycle.
- Output:
  - Each cycle, if the EX queue head is done, pop it into the trace_data_o register and pulse trace_valid.
  - Throughput is at most one record per cycle.
  - Latency: the record is visible 2 edges after decode_phase_end for non-memory ops, and 2 edges after data_mem_rvalid for memory ops, when the queue ahead of it is empty.
- repeat_detected: set when a record with instruction 0x0000006F (jal x0,0) is emitted; cleared only by reset.
- Full-FIFO push: the push is dropped, overflow is set, and existing contents are untouched.
- Reset asserted mid-operation discards all in-flight state on the next edge.

Decomposition:
- Package gouram_datatypes, typedef trace_format (packed), fields in MSB-first order:
  - instruction: 32 bits.
  - addr: 32 bits.
  - if_start, if_end, id_start, id_end, ex_start, ex_end: 32-bit signed each.
  - mem_addr: 32 bits.
- The package also holds the opcode constants OPC_LOAD, OPC_STORE and HALT_INSTR = 32'h0000006F.
- Sub-module: one parameterised sync_fifo (width, depth, push/pop/full/empty/count/clear).
  - Used for the IF pending FIFO and the IF fetched FIFO.
  - The EX queue is an indexed array, since entries are updated in place.

Test Plan:
- ALU op:
  - Stimulus: counter runs from 0; req+gnt addr 0x0010 at counter 2; rvalid rdata 0x00500093 at 4; decode_phase_end at 6.
  - Response: trace_valid at counter 8 with if 2/4, id 4/6, ex 6/7, mem_addr 0.
- Load:
  - Stimulus: rdata 0x0000A103 decoded at 6; data_mem_req addr 0x1000 at 7; rvalid at 9.
  - Response: ex 7/9, mem_addr 0x1000, trace_valid at 11.
- Ordering: a load then an ALU op; the ALU record is held until the load's rvalid, then records emit on consecutive cycles.
- Flush:
  - Stimulus: two grants outstanding, then pc_set; two rvalids; new grant 0x0040 answered.
  - Response: only the 0x0040 record is ever emitted.
- Overflow: 9 grants without rvalid (depth 8) -> overflow=1; the first 8 still trace correctly.
- Halt: decode 0x0000006F -> repeat_detected rises with its record and stays 1; rst_n low for one edge clears all outputs.

Source files
------------

// File: rtl/pipeline_trace_tracker_pkg.sv
// gouram_datatypes: shared types and constants for the pipeline trace tracker.
//   trace_format - one complete per-instruction trace record (MSB-first fields)
//   ex_entry_t   - EX queue slot: a record under construction plus its status
//   OPC_LOAD / OPC_STORE / HALT_INSTR - decode constants
package gouram_datatypes;

    typedef struct packed {
        logic        [31:0] instruction;
        logic        [31:0] addr;
        logic signed [31:0] if_start;
        logic signed [31:0] if_end;
        logic signed [31:0] id_start;
        logic signed [31:0] id_end;
        logic signed [31:0] ex_start;
        logic signed [31:0] ex_end;
        logic        [31:0] mem_addr;
    } trace_format;

    typedef struct packed {
        trace_format rec;
        logic        is_mem;     // load/store: waits for the data bus
        logic        requested;  // data request already attributed
        logic        done;       // record complete, may retire
    } ex_entry_t;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [31:0] HALT_INSTR = 32'h0000006F;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/pipeline_trace_tracker_if.sv
// Core probe bundle observed by the trace tracker.
//   instr_*          - OBI-style instruction fetch bus
//   decode_phase_end - ID hands its instruction to EX
//   pc_set           - PC redirect, flushes prefetched instructions
//   data_mem_*       - data bus request / response
// master: the core side driving the probes; slave: the tracker observing them.
interface pipeline_trace_tracker_if
    import gouram_datatypes::*;
#(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32
);
    logic                        instr_req;
    logic                        instr_gnt;
    logic [INSTR_ADDR_WIDTH-1:0] instr_addr;
    logic                        instr_rvalid;
    logic [INSTR_DATA_WIDTH-1:0] instr_rdata;
    logic                        decode_phase_end;
    logic                        pc_set;
    logic                        data_mem_req;
    logic [DATA_ADDR_WIDTH-1:0]  data_mem_addr;
    logic                        data_mem_rvalid;

    modport master (
        output instr_req, instr_gnt, instr_addr, instr_rvalid, instr_rdata,
        output decode_phase_end, pc_set,
        output data_mem_req, data_mem_addr, data_mem_rvalid
    );

    modport slave (
        input instr_req, instr_gnt, instr_addr, instr_rvalid, instr_rdata,
        input decode_phase_end, pc_set,
        input data_mem_req, data_mem_addr, data_mem_rvalid
    );
endinterface

// File: rtl/pipeline_trace_tracker_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous clear.
//   clk, rst_n (sync, active-low), clear (empties the FIFO)
//   push/push_data, pop/pop_data (head is visible combinationally)
//   full, empty, count
// A push while full is accepted only if a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop) & ~clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/pipeline_trace_tracker.sv
// pipeline_trace_tracker: cycle-stamped IF/ID/EX tracer for an in-order core.
//   clk, rst_n (sync, active-low)
//   counter          - free-running cycle count, sampled for every timestamp
//   probe            - core probe bundle (fetch bus, decode, redirect, data bus)
//   trace_data_o     - last retired record; valid while trace_valid pulses
//   trace_valid      - one-cycle pulse per retired instruction, program order
//   repeat_detected  - sticky, a jal x0,0 record was emitted
//   overflow         - sticky, some record was dropped on a full buffer
// TRACE_BUFFER_SIZE must be a power of two (EX queue pointers wrap naturally).
module pipeline_trace_tracker
    import gouram_datatypes::*;
#(
    parameter int INSTR_ADDR_WIDTH       = 16,
    parameter int INSTR_DATA_WIDTH       = 32,
    parameter int DATA_ADDR_WIDTH        = 32,
    parameter int IF_TRACKER_BUFFER_SIZE = 8,
    parameter int TRACE_BUFFER_SIZE      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [31:0]      counter,
    pipeline_trace_tracker_if.slave probe,
    output trace_format             trace_data_o,
    output logic                    trace_valid,
    output logic                    repeat_detected,
    output logic                    overflow
);
    localparam int IF_CNT_W = $clog2(IF_TRACKER_BUFFER_SIZE + 1);
    localparam int PEND_W   = INSTR_ADDR_WIDTH + 32;
    localparam int FETCH_W  = INSTR_DATA_WIDTH + INSTR_ADDR_WIDTH + 64;
    localparam int EX_PTR_W = (TRACE_BUFFER_SIZE > 1) ? $clog2(TRACE_BUFFER_SIZE) : 1;
    localparam int EX_CNT_W = $clog2(TRACE_BUFFER_SIZE + 1);

    // ---------------- IF pending: granted, awaiting rvalid ----------------
    logic                        pend_push, pend_pop, pend_full, pend_empty, pend_drop;
    logic [IF_CNT_W-1:0]         pend_count;
    logic [PEND_W-1:0]           pend_head;
    logic [INSTR_ADDR_WIDTH-1:0] pend_addr;
    logic signed [31:0]          pend_if_start;

    assign pend_push = probe.instr_req & probe.instr_gnt;
    assign pend_pop  = probe.instr_rvalid & ~pend_empty;
    assign pend_drop = pend_push & pend_full & ~pend_pop;
    assign {pend_addr, pend_if_start} = pend_head;

    sync_fifo #(.WIDTH(PEND_W), .DEPTH(IF_TRACKER_BUFFER_SIZE)) u_pend_fifo (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .push(pend_push), .push_data({probe.instr_addr, counter}),
        .pop(pend_pop), .pop_data(pend_head),
        .full(pend_full), .empty(pend_empty), .count(pend_count)
    );

    // Responses still owed to requests issued before a redirect are dropped.
    logic [IF_CNT_W-1:0] discard_reg, discard_next;
    logic                rvalid_keep;

    assign rvalid_keep = pend_pop & ~probe.pc_set & (discard_reg == '0);

    always_comb begin
        discard_next = discard_reg;
        if (probe.pc_set) begin
            // A same-cycle rvalid already consumes one stale entry; a same-cycle
            // grant is the redirect target and is not counted.
            discard_next = pend_count - IF_CNT_W'(pend_pop);
        end else if (pend_pop && discard_reg != '0) begin
            discard_next = discard_reg - IF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) discard_reg <= '0;
        else        discard_reg <= discard_next;
    end

    // ---------------- IF fetched: awaiting decode ----------------
    logic                        fetch_push, fetch_pop, fetch_full, fetch_empty, fetch_drop;
    logic [IF_CNT_W-1:0]         fetch_count_unused;
    logic [FETCH_W-1:0]          fetch_head;
    logic [INSTR_DATA_WIDTH-1:0] f_instr;
    logic [INSTR_ADDR_WIDTH-1:0] f_addr;
    logic signed [31:0]          f_if_start, f_if_end;

    assign fetch_push = rvalid_keep;
    assign fetch_pop  = probe.decode_phase_end & ~fetch_empty;
    assign fetch_drop = fetch_push & fetch_full & ~fetch_pop;
    assign {f_instr, f_addr, f_if_start, f_if_end} = fetch_head;

    // pc_set clears after the same-cycle decode pop has been taken from the head.
    sync_fifo #(.WIDTH(FETCH_W), .DEPTH(IF_TRACKER_BUFFER_SIZE)) u_fetch_fifo (
        .clk(clk), .rst_n(rst_n), .clear(probe.pc_set),
        .push(fetch_push), .push_data({probe.instr_rdata, pend_addr, pend_if_start, counter}),
        .pop(fetch_pop), .pop_data(fetch_head),
        .full(fetch_full), .empty(fetch_empty), .count(fetch_count_unused)
    );

    // ---------------- EX in-order queue, updated in place ----------------
    ex_entry_t                  ex_q_reg [TRACE_BUFFER_SIZE];
    logic [EX_PTR_W-1:0]        ex_head_reg, ex_tail_reg;
    logic [EX_CNT_W-1:0]        ex_count_reg;
    logic [EX_PTR_W-1:0]        ord_idx [TRACE_BUFFER_SIZE];
    logic [DATA_ADDR_WIDTH-1:0] data_addr;
    ex_entry_t                  new_entry;
    logic                       ex_push, ex_pop, ex_drop;
    logic                       req_found, rsp_found;
    logic [EX_PTR_W-1:0]        req_idx, rsp_idx;

    assign data_addr = probe.data_mem_addr;

    always_comb begin
        new_entry                 = '0;
        new_entry.rec.instruction = 32'(f_instr);
        new_entry.rec.addr        = 32'(f_addr);
        new_entry.rec.if_start    = f_if_start;
        new_entry.rec.if_end      = f_if_end;
        new_entry.rec.id_start    = f_if_end;
        new_entry.rec.id_end      = counter;
        new_entry.is_mem          = is_mem_op(f_instr[6:0]);
        if (!new_entry.is_mem) begin
            new_entry.rec.ex_start = counter;
            new_entry.rec.ex_end   = counter + 32'sd1;
            new_entry.done         = 1'b1;
        end
    end

    // ord_idx[k] is the slot holding the k-th oldest entry.
    genvar gi;
    generate
        for (gi = 0; gi < TRACE_BUFFER_SIZE; gi++) begin : g_ord
            assign ord_idx[gi] = ex_head_reg + EX_PTR_W'(gi);
        end
    endgenerate

    // Oldest un-requested memory op owns a data request; oldest requested,
    // unfinished op owns a data response. Both may fire in one cycle.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        rsp_found = 1'b0;
        rsp_idx   = '0;
        for (int i = 0; i < TRACE_BUFFER_SIZE; i++) begin
            if (EX_CNT_W'(i) < ex_count_reg) begin
                if (!req_found && ex_q_reg[ord_idx[i]].is_mem && !ex_q_reg[ord_idx[i]].requested) begin
                    req_found = 1'b1;
                    req_idx   = ord_idx[i];
                end
                if (!rsp_found && ex_q_reg[ord_idx[i]].requested && !ex_q_reg[ord_idx[i]].done) begin
                    rsp_found = 1'b1;
                    rsp_idx   = ord_idx[i];
                end
            end
        end
    end

    assign ex_pop  = (ex_count_reg != '0) && ex_q_reg[ex_head_reg].done;
    assign ex_push = fetch_pop && ((ex_count_reg != EX_CNT_W'(TRACE_BUFFER_SIZE)) || ex_pop);
    assign ex_drop = fetch_pop && !ex_push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TRACE_BUFFER_SIZE; i++) ex_q_reg[i] <= '0;
            ex_head_reg  <= '0;
            ex_tail_reg  <= '0;
            ex_count_reg <= '0;
        end else begin
            if (req_found && probe.data_mem_req) begin
                ex_q_reg[req_idx].requested    <= 1'b1;
                ex_q_reg[req_idx].rec.ex_start <= counter;
                ex_q_reg[req_idx].rec.mem_addr <= 32'(data_addr);
            end
            if (rsp_found && probe.data_mem_rvalid) begin
                ex_q_reg[rsp_idx].done       <= 1'b1;
                ex_q_reg[rsp_idx].rec.ex_end <= counter;
            end
            if (ex_push) begin
                ex_q_reg[ex_tail_reg] <= new_entry;
                ex_tail_reg           <= ex_tail_reg + EX_PTR_W'(1);
            end
            if (ex_pop) ex_head_reg <= ex_head_reg + EX_PTR_W'(1);
            ex_count_reg <= ex_count_reg + EX_CNT_W'(ex_push) - EX_CNT_W'(ex_pop);
        end
    end

    // ---------------- Output register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_data_o    <= '0;
            trace_valid     <= 1'b0;
            repeat_detected <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            trace_valid <= ex_pop;
            if (ex_pop) begin
                trace_data_o <= ex_q_reg[ex_head_reg].rec;
                if (ex_q_reg[ex_head_reg].rec.instruction == HALT_INSTR) repeat_detected <= 1'b1;
            end
            if (pend_drop || fetch_drop || ex_drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Bench for pipeline_trace_tracker: directed scenarios with hand-computed
// records, then random probe traffic checked cycle by cycle against a
// queue-based reference model of the tracing rules.
module tb_pipeline_trace_tracker;
    import gouram_datatypes::*;

    localparam int IFD = 8;
    localparam int TBD = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [31:0] counter;
    trace_format        trace_data_o;
    logic               trace_valid, repeat_detected, overflow;

    always #5 clk = ~clk;

    pipeline_trace_tracker_if bus ();

    pipeline_trace_tracker dut (
        .clk(clk), .rst_n(rst_n), .counter(counter), .probe(bus.slave),
        .trace_data_o(trace_data_o), .trace_valid(trace_valid),
        .repeat_detected(repeat_detected), .overflow(overflow)
    );

    // ---------------- reference model state ----------------
    typedef struct { logic [15:0] addr; int start; } pend_t;
    typedef struct { logic [31:0] instr; logic [15:0] addr; int if_start; int if_end; } fetch_t;
    typedef struct { trace_format rec; bit is_mem; bit req; bit done; } ex_t;
    typedef struct { trace_format rec; int at; } got_t;

    pend_t       pq[$];
    fetch_t      fq[$];
    ex_t         xq[$];
    got_t        got_q[$];
    int          discard;
    bit          exp_valid, exp_rep, exp_ovf;
    trace_format exp_rec;
    int          total = 0;
    int          bad   = 0;

    task automatic check_val(input string tag, input logic [351:0] got, input logic [351:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic trace_format mk_rec(input logic [31:0] instr, input logic [31:0] addr,
                                           input int ifs, input int ife, input int ids, input int ide,
                                           input int exs, input int exe, input logic [31:0] mem);
        trace_format r;
        r.instruction = instr; r.addr = addr;
        r.if_start = ifs; r.if_end = ife; r.id_start = ids; r.id_end = ide;
        r.ex_start = exs; r.ex_end = exe; r.mem_addr = mem;
        return r;
    endfunction

    // Applies one clock edge worth of tracing rules to the model.
    task automatic model_edge();
        bit     pop_out;
        int     ri, vi;
        pend_t  p;
        fetch_t f;
        ex_t    e;
        if (!rst_n) begin
            pq.delete(); fq.delete(); xq.delete();
            discard = 0; exp_valid = 0; exp_rec = '0; exp_rep = 0; exp_ovf = 0;
            return;
        end
        pop_out = (xq.size() > 0) && xq[0].done;
        ri = -1; vi = -1;
        for (int i = 0; i < xq.size(); i++) begin
            if (ri < 0 && xq[i].is_mem && !xq[i].req) ri = i;
            if (vi < 0 && xq[i].req && !xq[i].done) vi = i;
        end
        if (bus.data_mem_req && ri >= 0) begin
            xq[ri].req = 1; xq[ri].rec.ex_start = counter; xq[ri].rec.mem_addr = bus.data_mem_addr;
        end
        if (bus.data_mem_rvalid && vi >= 0) begin
            xq[vi].done = 1; xq[vi].rec.ex_end = counter;
        end
        if (bus.decode_phase_end && fq.size() > 0) begin
            f = fq.pop_front();
            e.rec = mk_rec(f.instr, {16'h0, f.addr}, f.if_start, f.if_end, f.if_end, counter, 0, 0, 0);
            e.is_mem = (f.instr[6:0] == 7'h03) || (f.instr[6:0] == 7'h23);
            e.req = 0;
            e.done = !e.is_mem;
            if (!e.is_mem) begin
                e.rec.ex_start = counter;
                e.rec.ex_end   = counter + 1;
            end
            if (xq.size() - int'(pop_out) < TBD) xq.push_back(e);
            else exp_ovf = 1;
        end
        if (bus.instr_rvalid && pq.size() > 0) begin
            p = pq.pop_front();
            if (bus.pc_set) begin
            end else if (discard > 0) begin
                discard--;
            end else if (fq.size() < IFD) begin
                fq.push_back('{instr: bus.instr_rdata, addr: p.addr, if_start: p.start, if_end: counter});
            end else begin
                exp_ovf = 1;
            end
        end
        if (bus.pc_set) begin
            fq.delete();
            discard = pq.size();
        end
        if (bus.instr_req && bus.instr_gnt) begin
            if (pq.size() < IFD) pq.push_back('{addr: bus.instr_addr, start: counter});
            else exp_ovf = 1;
        end
        exp_valid = pop_out;
        if (pop_out) begin
            exp_rec = xq[0].rec;
            void'(xq.pop_front());
            if (exp_rec.instruction == 32'h0000006F) exp_rep = 1;
        end
    endtask

    task automatic clear_inputs();
        bus.instr_req = 0; bus.instr_gnt = 0; bus.instr_addr = '0;
        bus.instr_rvalid = 0; bus.instr_rdata = '0;
        bus.decode_phase_end = 0; bus.pc_set = 0;
        bus.data_mem_req = 0; bus.data_mem_addr = '0; bus.data_mem_rvalid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        counter = counter + 1;
        check_val("trace_valid", trace_valid, exp_valid);
        if (exp_valid || !rst_n) check_val("trace_data", trace_data_o, exp_rec);
        check_val("overflow", overflow, exp_ovf);
        check_val("repeat_detected", repeat_detected, exp_rep);
        if (trace_valid) begin
            got_q.push_back('{rec: trace_data_o, at: counter});
            $display("trace @%0d addr=%h instr=%h if=%0d/%0d id=%0d/%0d ex=%0d/%0d mem=%h",
                     counter, trace_data_o.addr, trace_data_o.instruction,
                     trace_data_o.if_start, trace_data_o.if_end, trace_data_o.id_start,
                     trace_data_o.id_end, trace_data_o.ex_start, trace_data_o.ex_end,
                     trace_data_o.mem_addr);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        counter = 0;
        got_q.delete();
    endtask

    task automatic check_rec(input string tag, input int idx, input int at, input trace_format rec);
        if (idx >= got_q.size()) begin
            check_val({tag, "_missing"}, got_q.size(), idx + 1);
            return;
        end
        check_val({tag, "_at"}, got_q[idx].at, at);
        check_val({tag, "_rec"}, got_q[idx].rec, rec);
    endtask

    initial begin
        counter = 0;
        rst_n   = 0;
        clear_inputs();
        tick();
        do_reset();

        // ALU op
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            case (c)
                2: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0010; end
                4: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h00500093; end
                6: bus.decode_phase_end = 1;
                default: ;
            endcase
            tick();
        end
        check_val("alu_count", got_q.size(), 1);
        check_rec("alu", 0, 8, mk_rec(32'h00500093, 32'h10, 2, 4, 4, 6, 6, 7, 0));

        // Load
        do_reset();
        for (int c = 0; c < 13; c++) begin
            clear_inputs();
            case (c)
                2: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0014; end
                4: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h0000A103; end
                6: bus.decode_phase_end = 1;
                7: begin bus.data_mem_req = 1; bus.data_mem_addr = 32'h1000; end
                9: bus.data_mem_rvalid = 1;
                default: ;
            endcase
            tick();
        end
        check_rec("load", 0, 11, mk_rec(32'h0000A103, 32'h14, 2, 4, 4, 6, 7, 9, 32'h1000));

        // Ordering: ALU record waits behind the load
        do_reset();
        for (int c = 0; c < 14; c++) begin
            clear_inputs();
            case (c)
                0: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0020; end
                1: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0024; end
                2: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h00002183; end
                3: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h00308093; end
                4, 5: bus.decode_phase_end = 1;
                6: begin bus.data_mem_req = 1; bus.data_mem_addr = 32'h2000; end
                8: bus.data_mem_rvalid = 1;
                default: ;
            endcase
            tick();
        end
        check_val("order_count", got_q.size(), 2);
        check_rec("order_load", 0, 10, mk_rec(32'h00002183, 32'h20, 0, 2, 2, 4, 6, 8, 32'h2000));
        check_rec("order_alu", 1, 11, mk_rec(32'h00308093, 32'h24, 1, 3, 3, 5, 5, 6, 0));

        // Flush: prefetched and in-flight instructions vanish, target survives
        do_reset();
        for (int c = 0; c < 13; c++) begin
            clear_inputs();
            case (c)
                0: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h002C; end
                1: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0030; end
                2: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0034;
                         bus.instr_rvalid = 1; bus.instr_rdata = 32'h00000013; end
                3: begin bus.pc_set = 1; bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0040; end
                4, 5: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h00700713; end
                6: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h00100013; end
                7: bus.decode_phase_end = 1;
                default: ;
            endcase
            tick();
        end
        check_val("flush_count", got_q.size(), 1);
        check_rec("flush", 0, 9, mk_rec(32'h00100013, 32'h40, 3, 6, 6, 7, 7, 8, 0));

        // Overflow: ninth outstanding grant is dropped
        do_reset();
        for (int c = 0; c < 30; c++) begin
            clear_inputs();
            if (c < 9) begin
                bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'(16'h0100 + 4 * c);
            end else if (c < 17) begin
                bus.instr_rvalid = 1; bus.instr_rdata = 32'h00000093 + 32'(c) * 32'h00100000;
            end else if (c < 25) begin
                bus.decode_phase_end = 1;
            end
            tick();
            if (c == 8) check_val("ovf_set", overflow, 1);
        end
        check_val("ovf_count", got_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_rec("ovf_rec", k, 19 + k,
                      mk_rec(32'h00000093 + 32'(9 + k) * 32'h00100000, 32'(32'h100 + 4 * k),
                             k, 9 + k, 9 + k, 17 + k, 17 + k, 18 + k, 0));
        end

        // Halt detection and reset
        do_reset();
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            case (c)
                0: begin bus.instr_req = 1; bus.instr_gnt = 1; bus.instr_addr = 16'h0050; end
                1: begin bus.instr_rvalid = 1; bus.instr_rdata = 32'h0000006F; end
                2: bus.decode_phase_end = 1;
                default: ;
            endcase
            tick();
        end
        check_rec("halt", 0, 4, mk_rec(32'h0000006F, 32'h50, 0, 1, 1, 2, 2, 3, 0));
        check_val("halt_sticky", repeat_detected, 1);
        rst_n = 0;
        tick();
        check_val("rst_valid", trace_valid, 0);
        check_val("rst_repeat", repeat_detected, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_data", trace_data_o, 0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            int sel;
            clear_inputs();
            bus.instr_req    = ($urandom_range(0, 99) < 50);
            bus.instr_gnt    = bus.instr_req && ($urandom_range(0, 99) < 60);
            bus.instr_addr   = 16'($urandom);
            bus.instr_rvalid = ($urandom_range(0, 99) < 40);
            sel = $urandom_range(0, 99);
            if (sel < 30)      bus.instr_rdata = {$urandom_range(0, 32'h1FFFFFF), 7'h03};
            else if (sel < 60) bus.instr_rdata = {$urandom_range(0, 32'h1FFFFFF), 7'h23};
            else if (sel < 97) bus.instr_rdata = {$urandom_range(0, 32'h1FFFFFF), 7'h13};
            else               bus.instr_rdata = 32'h0000006F;
            bus.decode_phase_end = ($urandom_range(0, 99) < 40);
            bus.pc_set           = ($urandom_range(0, 99) < 3);
            bus.data_mem_req     = ($urandom_range(0, 99) < 35);
            bus.data_mem_addr    = $urandom;
            bus.data_mem_rvalid  = ($urandom_range(0, 99) < 35);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
